// File: rtl/hazard_forward_tracker_if.sv
// Decode-side bundle for the hazard/forwarding tracker: pre-decoded
// register fields and pipeline controls in, bypass selects and stall out.
interface hazard_forward_tracker_if #(
    parameter int REG_ADDR_W = 3,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int CNT_W      = 16
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic                          dec_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] dec_src_addr;
    logic [NUM_SRC-1:0]            dec_src_used;
    logic [REG_ADDR_W-1:0]         dec_dst_addr;
    logic                          dec_dst_we;
    logic                          dec_is_load;
    logic                          pipe_hold;
    logic                          flush;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
    logic                          stall_dec;
    logic [CNT_W-1:0]              stall_count;

    // Decode stage / pipeline control side
    modport master (
        output dec_valid, dec_src_addr, dec_src_used, dec_dst_addr,
               dec_dst_we, dec_is_load, pipe_hold, flush,
        input  fwd_sel, stall_dec, stall_count
    );

    // Tracker side
    modport slave (
        input  dec_valid, dec_src_addr, dec_src_used, dec_dst_addr,
               dec_dst_we, dec_is_load, pipe_hold, flush,
        output fwd_sel, stall_dec, stall_count
    );
endinterface

// File: rtl/hazard_forward_tracker.sv
// Decode-stage hazard and forwarding controller. Tracks in-flight
// destination registers in a shift register mirroring EX/MEM/WB and
// derives per-operand bypass selects plus a load-use stall.
module hazard_forward_tracker #(
    parameter int REG_ADDR_W = 3,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_AVAIL = 1,
    parameter int ZERO_REG   = 0,
    parameter int CNT_W      = 16
) (
    input logic                    clk,
    input logic                    rst,
    hazard_forward_tracker_if.slave bus
);
    localparam int          SEL_W        = $clog2(DEPTH + 1);
    localparam int unsigned DEPTH_U      = DEPTH;
    localparam int unsigned NUM_SRC_U    = NUM_SRC;
    localparam int unsigned LOAD_AVAIL_U = LOAD_AVAIL;

    // Tracked entries: index 0 = EX, 1 = MEM, ..., DEPTH-1 = WB
    logic [DEPTH-1:0]      ent_valid;
    logic [DEPTH-1:0]      ent_we;
    logic [DEPTH-1:0]      ent_load;
    logic [REG_ADDR_W-1:0] ent_addr [DEPTH];

    logic [NUM_SRC-1:0]       hazard;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic                     stall_dec;
    logic                     accept;
    logic [CNT_W-1:0]         stall_count;

    // Per-operand youngest-producer search and bypass/hazard resolution
    always_comb begin : match
        logic [REG_ADDR_W-1:0] src;
        logic                  hit;
        logic                  hit_load;
        int unsigned           hit_idx;
        int unsigned           k;
        hazard   = '0;
        fwd_sel  = '0;
        src      = '0;
        hit      = 1'b0;
        hit_load = 1'b0;
        hit_idx  = 0;
        k        = 0;
        for (int unsigned j = 0; j < NUM_SRC_U; j++) begin
            src      = bus.dec_src_addr[j*REG_ADDR_W +: REG_ADDR_W];
            hit      = 1'b0;
            hit_load = 1'b0;
            hit_idx  = 0;
            // Scan oldest to youngest so the youngest match is the one kept
            for (int unsigned i = 0; i < DEPTH_U; i++) begin
                k = DEPTH_U - 1 - i;
                if (ent_valid[k] && ent_we[k] && (ent_addr[k] == src)) begin
                    hit      = 1'b1;
                    hit_load = ent_load[k];
                    hit_idx  = k;
                end
            end
            if (!bus.dec_src_used[j] || ((ZERO_REG != 0) && (src == '0))) begin
                hit = 1'b0;
            end
            if (hit) begin
                if (hit_load && (hit_idx < LOAD_AVAIL_U)) begin
                    hazard[j] = 1'b1;
                end else begin
                    fwd_sel[j*SEL_W +: SEL_W] = SEL_W'(hit_idx + 1);
                end
            end
        end
    end

    // Stall and acceptance qualifiers; flush overrides any stall
    always_comb begin
        stall_dec = bus.dec_valid & ~bus.flush & (|hazard);
        accept    = bus.dec_valid & ~stall_dec & ~bus.flush;
    end

    // Entry valid bits: shift on advance, flush kills EX and the EX->MEM move
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
        end else if (!bus.pipe_hold) begin
            ent_valid[0] <= accept;
            for (int unsigned k = 1; k < DEPTH_U; k++) begin
                ent_valid[k] <= ent_valid[k-1];
            end
            if (bus.flush) begin
                ent_valid[1] <= 1'b0;
            end
        end else if (bus.flush) begin
            ent_valid[0] <= 1'b0;
        end
    end

    // Entry payload: loaded from decode and shifted on advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_we   <= '0;
            ent_load <= '0;
            for (int unsigned k = 0; k < DEPTH_U; k++) begin
                ent_addr[k] <= '0;
            end
        end else if (!bus.pipe_hold) begin
            ent_we[0]   <= bus.dec_dst_we;
            ent_load[0] <= bus.dec_is_load;
            ent_addr[0] <= bus.dec_dst_addr;
            for (int unsigned k = 1; k < DEPTH_U; k++) begin
                ent_we[k]   <= ent_we[k-1];
                ent_load[k] <= ent_load[k-1];
                ent_addr[k] <= ent_addr[k-1];
            end
        end
    end

    // Saturating count of stall cycles that actually cost a pipeline slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall_dec && !bus.pipe_hold && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    assign bus.fwd_sel     = fwd_sel;
    assign bus.stall_dec   = stall_dec;
    assign bus.stall_count = stall_count;

endmodule

// File: tb/tb_hazard_forward_tracker.sv
// Scoreboard bench for hazard_forward_tracker: directed stimulus pushes
// hand-computed expectations; a negedge monitor pops and compares.
module tb_hazard_forward_tracker;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // dut_a: defaults; dut_b: LOAD_AVAIL=2, ZERO_REG=1, CNT_W=4
    hazard_forward_tracker_if #(.REG_ADDR_W(3), .NUM_SRC(2), .DEPTH(3), .CNT_W(16)) ifa ();
    hazard_forward_tracker_if #(.REG_ADDR_W(3), .NUM_SRC(2), .DEPTH(3), .CNT_W(4))  ifb ();

    hazard_forward_tracker #(
        .REG_ADDR_W(3), .NUM_SRC(2), .DEPTH(3), .LOAD_AVAIL(1), .ZERO_REG(0), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );

    hazard_forward_tracker #(
        .REG_ADDR_W(3), .NUM_SRC(2), .DEPTH(3), .LOAD_AVAIL(2), .ZERO_REG(1), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    typedef struct {
        int         dut;
        string      name;
        logic [3:0] sel;
        logic       stall;
        int         count;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: one expectation checked per cycle, away from the rising edge
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] s;
        logic       st;
        int         c;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.dut == 0) begin
                s  = ifa.fwd_sel;
                st = ifa.stall_dec;
                c  = int'(ifa.stall_count);
            end else begin
                s  = ifb.fwd_sel;
                st = ifb.stall_dec;
                c  = int'(ifb.stall_count);
            end
            n_cmp++;
            if ((s !== e.sel) || (st !== e.stall) || (c != e.count)) begin
                n_bad++;
                $display("FAIL %s: got sel=%h stall=%b count=%0d, want sel=%h stall=%b count=%0d",
                         e.name, s, st, c, e.sel, e.stall, e.count);
            end
        end
    end

    task automatic drv(input int d, input logic v, input logic [2:0] rs, input logic [2:0] rt,
                       input logic [1:0] used, input logic [2:0] dst, input logic we,
                       input logic ld, input logic hold, input logic fl);
        if (d == 0) begin
            ifa.dec_valid = v; ifa.dec_src_addr = {rt, rs}; ifa.dec_src_used = used;
            ifa.dec_dst_addr = dst; ifa.dec_dst_we = we; ifa.dec_is_load = ld;
            ifa.pipe_hold = hold; ifa.flush = fl;
        end else begin
            ifb.dec_valid = v; ifb.dec_src_addr = {rt, rs}; ifb.dec_src_used = used;
            ifb.dec_dst_addr = dst; ifb.dec_dst_we = we; ifb.dec_is_load = ld;
            ifb.pipe_hold = hold; ifb.flush = fl;
        end
    endtask

    task automatic expect_out(input int d, input string nm, input logic [3:0] sel,
                              input logic st, input int cnt);
        exp_t e;
        e.dut = d; e.name = nm; e.sel = sel; e.stall = st; e.count = cnt;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        drv(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    endtask

    task automatic drain(input int n);
        idle_all();
        repeat (n) step();
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expect_out(0, "reset_a", 4'h0, 1'b0, 0); step();
        expect_out(1, "reset_b", 4'h0, 1'b0, 0); step();

        // ALU chain on r3: bypass select walks 1,2,3 then register file
        drv(0, 1, 0, 0, 2'b00, 3, 1, 0, 0, 0);
        expect_out(0, "alu_c0", 4'h0, 1'b0, 0); step();
        drv(0, 1, 3, 0, 2'b01, 7, 0, 0, 0, 0);
        expect_out(0, "alu_c1", 4'h1, 1'b0, 0); step();
        expect_out(0, "alu_c2", 4'h2, 1'b0, 0); step();
        expect_out(0, "alu_c3", 4'h3, 1'b0, 0); step();
        expect_out(0, "alu_c4", 4'h0, 1'b0, 0); step();
        drain(3);

        // Adjacent load-use on Rt: one stall, then forward from MEM
        drv(0, 1, 0, 0, 2'b00, 5, 1, 1, 0, 0);
        expect_out(0, "lu_c0", 4'h0, 1'b0, 0); step();
        drv(0, 1, 0, 5, 2'b10, 7, 0, 0, 0, 0);
        expect_out(0, "lu_stall", 4'h0, 1'b1, 0); step();
        expect_out(0, "lu_fwd", 4'h8, 1'b0, 1); step();
        drain(3);

        // Younger ALU write shadows an older load of the same register
        drv(0, 1, 0, 0, 2'b00, 2, 1, 1, 0, 0); step();
        drv(0, 1, 0, 0, 2'b00, 2, 1, 0, 0, 0);
        expect_out(0, "yw_alu", 4'h0, 1'b0, 1); step();
        drv(0, 1, 2, 0, 2'b01, 7, 0, 0, 0, 0);
        expect_out(0, "yw_fwd", 4'h1, 1'b0, 1); step();
        drain(3);

        // Hold freezes the load in EX; flush then kills it in place
        drv(0, 1, 0, 0, 2'b00, 4, 1, 1, 0, 0); step();
        drv(0, 1, 4, 0, 2'b01, 7, 0, 0, 1, 0);
        expect_out(0, "hold_1", 4'h0, 1'b1, 1); step();
        expect_out(0, "hold_2", 4'h0, 1'b1, 1); step();
        expect_out(0, "hold_3", 4'h0, 1'b1, 1); step();
        drv(0, 1, 4, 0, 2'b01, 7, 0, 0, 1, 1);
        expect_out(0, "hold_flush", 4'h0, 1'b0, 1); step();
        drv(0, 1, 4, 0, 2'b01, 7, 0, 0, 1, 0);
        expect_out(0, "hold_after_flush", 4'h0, 1'b0, 1); step();
        drain(3);

        // Flush while advancing: no stall counted, load never reaches MEM
        drv(0, 1, 0, 0, 2'b00, 4, 1, 1, 0, 0); step();
        drv(0, 1, 4, 0, 2'b01, 7, 0, 0, 0, 1);
        expect_out(0, "flush_stall", 4'h0, 1'b0, 1); step();
        drv(0, 1, 4, 0, 2'b01, 7, 0, 0, 0, 0);
        expect_out(0, "flush_gone", 4'h0, 1'b0, 1); step();
        drain(3);

        // Matching address on operands that do not read their register
        drv(0, 1, 0, 0, 2'b00, 6, 1, 0, 0, 0); step();
        drv(0, 1, 6, 6, 2'b00, 7, 0, 0, 0, 0);
        expect_out(0, "unused_op", 4'h0, 1'b0, 1); step();
        drain(3);

        // LOAD_AVAIL=2: two stalls, then forward from WB
        drv(1, 1, 0, 0, 2'b00, 5, 1, 1, 0, 0); step();
        drv(1, 1, 0, 5, 2'b10, 7, 0, 0, 0, 0);
        expect_out(1, "lu2_s1", 4'h0, 1'b1, 0); step();
        expect_out(1, "lu2_s2", 4'h0, 1'b1, 1); step();
        expect_out(1, "lu2_fwd", 4'hC, 1'b0, 2); step();
        drain(3);

        // Hardwired zero register never forwards
        drv(1, 1, 0, 0, 2'b00, 0, 1, 0, 0, 0); step();
        drv(1, 1, 0, 0, 2'b01, 7, 0, 0, 0, 0);
        expect_out(1, "zero_reg", 4'h0, 1'b0, 2); step();
        drain(3);

        // Self-dependent load chain: 2 stalls per 3 cycles, 20 in 30 cycles
        drv(1, 1, 1, 0, 2'b01, 1, 1, 1, 0, 0);
        repeat (30) step();
        idle_all();
        expect_out(1, "sat", 4'h0, 1'b0, 15); step();

        // Asynchronous reset mid-cycle, checked before the next rising edge
        drv(1, 1, 1, 0, 2'b01, 7, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        expect_out(1, "async_rst", 4'h0, 1'b0, 0); step();

        drain(3);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
